mem_dma: RTL and testbench
==========================

// Module: mem_dma
// PURPOSE
//  Word-granular memory-to-memory copy engine. Mastered by the core through a mem_req_t/mem_resp_t
//  responder port (config), it acts as an initiator on a second mem_req_t/mem_resp_t port.
//  Integrated on a free mem_noc_router_1to4 slave slot (config) and a mem_noc master slot (copy).
//  Raises a level irq on completion for the plic ext_irq_src vector.
// PARAMETERS
//  LEN_W      16  width of LEN/REMAIN word counters (max copy = 2**LEN_W-1 words)
//  OFS_W      5   config port address bits decoded (byte offset, addr[OFS_W-1:0])
// PORTS
//  clk             in   1     single clock
//  rst             in   1     reset, synchronous, active-high
//  cfg_req_valid   in   1     config request valid
//  cfg_req_ready   out  1     config request ready
//  cfg_req         in   mem_req_t   config request (addr, wdata, we used; wstrb ignored)
//  cfg_resp_valid  out  1     config response valid
//  cfg_resp_ready  in   1     config response ready
//  cfg_resp        out  mem_resp_t  config response (rdata)
//  dma_req_valid   out  1     copy request valid
//  dma_req_ready   in   1     copy request ready
//  dma_req         out  mem_req_t   copy request (addr, wdata, wstrb=4'hF, we)
//  dma_resp_valid  in   1     copy response valid
//  dma_resp_ready  out  1     copy response ready
//  dma_resp        in   mem_resp_t  copy response (rdata)
//  dma_irq         out  1     level interrupt = STATUS.done & CTRL.irq_en
// BEHAVIOUR
//  Interface: one clock; reset is synchronous and active-high.
//  Reset (rst=1 at posedge): all regs 0, FSM=IDLE, every *_valid/ready out 0, dma_irq 0. Reset
//   mid-copy abandons the transfer immediately; an outstanding bus beat is dropped (system-level reset).
//  Register map (word offsets, full-word writes): 0x00 SRC rw, 0x04 DST rw, 0x08 LEN rw [LEN_W-1:0],
//   0x0C CTRL: b0 start (W1, reads 0), b1 irq_en rw; 0x10 STATUS: b0 busy ro, b1 done W1C;
//   0x14 REMAIN ro. Unmapped: read 0, write ignored.
//  Config port: one outstanding. cfg_req_ready = !cfg_resp_valid. Accepted req -> cfg_resp_valid
//   next cycle with rdata (0 for writes); held until cfg_resp_ready. Write takes effect on accept edge.
//  While busy: writes to SRC/DST/LEN ignored, start ignored; CTRL.irq_en and done W1C still honoured.
//  Start: copies SRC/DST/LEN into working addr regs and REMAIN, clears done, busy=1.
//   LEN==0 -> done=1 next cycle, busy stays 0, no dma traffic.
//  FSM: IDLE -> RD_REQ (start, LEN!=0) -> RD_RESP (req handshake) -> WR_REQ (resp handshake,
//   data reg <= rdata) -> WR_RESP (req handshake) -> RD_REQ if REMAIN>1 else DONE; DONE -> IDLE
//   (done=1, busy=0). Each word: src+=4, dst+=4, REMAIN-=1 on WR_RESP handshake.
//  dma_req_valid high only in RD_REQ/WR_REQ; once high, req and valid stay stable until ready.
//  dma_resp_ready high only in RD_RESP/WR_RESP. Min throughput 4 cycles/word with 1-cycle responder.
//  Addresses wrap modulo 2**32 (no error). Misaligned SRC/DST: low 2 bits forced 0 on dma_req.addr.
//  Start write and done W1C in same access: start wins (done ends 0).
//  Completion coincident with a done W1C write: set wins (done=1).
// STRUCTURE
//  urv_cfg: DMA_SRC/DST/LEN/CTRL/STATUS/REMAIN_OFS constants, DMA_LEN_W default.
//  urv_typedef: dma_state_e enum (IDLE, RD_REQ, RD_RESP, WR_REQ, WR_RESP, DONE).
//  Sub-module mem_dma_regs: config responder + register file; mem_dma holds FSM and datapath.
// TESTING
//  SRC=0x8000_0000, DST=0x8000_0100, LEN=4, start -> 4 words copied in order, done=1, REMAIN=0, 16 cyc min.
//  LEN=0, start -> done=1 next cycle, zero dma_req_valid cycles, dma_irq per irq_en.
//  Random dma_req_ready/dma_resp_valid stalls (0-5 cyc) -> req fields stable while valid&!ready, data intact.
//  Write SRC=0x1234 and start while busy -> ignored; running copy unchanged, SRC reads old value.
//  SRC=0xFFFF_FFFC, LEN=2 -> reads at 0xFFFF_FFFC then 0x0000_0000.
//  rst asserted in WR_REQ -> next cycle dma_req_valid=0, busy=0, all regs read 0.

Source files
------------

// File: rtl/mem_dma_pkg.sv
// Shared types and constants for the mem_dma copy engine: bus structs,
// register offsets and the copy FSM state encoding.
package mem_dma_pkg;

    localparam int DMA_LEN_W = 16;
    localparam int DMA_OFS_W = 5;

    localparam logic [31:0] DMA_SRC_OFS    = 32'h00;
    localparam logic [31:0] DMA_DST_OFS    = 32'h04;
    localparam logic [31:0] DMA_LEN_OFS    = 32'h08;
    localparam logic [31:0] DMA_CTRL_OFS   = 32'h0C;
    localparam logic [31:0] DMA_STATUS_OFS = 32'h10;
    localparam logic [31:0] DMA_REMAIN_OFS = 32'h14;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        we;
    } mem_req_t;

    typedef struct packed {
        logic [31:0] rdata;
    } mem_resp_t;

    typedef enum logic [2:0] {
        IDLE,
        RD_REQ,
        RD_RESP,
        WR_REQ,
        WR_RESP,
        DONE
    } dma_state_e;

    function automatic logic [31:0] word_align(input logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/mem_dma_regs.sv
// Config responder and register file: one outstanding request, response the
// cycle after accept, held until taken.
module mem_dma_regs
    import mem_dma_pkg::*;
#(
    parameter int LEN_W = DMA_LEN_W,
    parameter int OFS_W = DMA_OFS_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_req_valid,
    output logic             cfg_req_ready,
    input  mem_req_t         cfg_req,
    output logic             cfg_resp_valid,
    input  logic             cfg_resp_ready,
    output mem_resp_t        cfg_resp,
    input  logic             active_i,
    input  logic             busy_i,
    input  logic             done_set_i,
    input  logic [LEN_W-1:0] remain_i,
    output logic             start_o,
    output logic [31:0]      src_o,
    output logic [31:0]      dst_o,
    output logic [LEN_W-1:0] len_o,
    output logic             done_o,
    output logic             irq_en_o
);

    logic [31:0]      src_q, src_d;
    logic [31:0]      dst_q, dst_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic             irq_en_q, irq_en_d;
    logic             done_q, done_d;
    logic             resp_valid_q, resp_valid_d;
    logic [31:0]      rdata_q, rdata_d;

    logic        accept;
    logic        wr;
    logic [31:0] ofs;
    logic [31:0] read_mux;
    logic        unused_cfg;

    assign cfg_req_ready = !rst && !resp_valid_q;
    assign accept        = cfg_req_valid && cfg_req_ready;
    assign wr            = accept && cfg_req.we;
    assign ofs           = 32'(cfg_req.addr[OFS_W-1:0]);
    assign start_o       = wr && (ofs == DMA_CTRL_OFS) && cfg_req.wdata[0] && !active_i;
    assign unused_cfg    = ^{cfg_req.wstrb, cfg_req.addr[31:OFS_W]};

    always_comb begin
        read_mux = '0;
        case (ofs)
            DMA_SRC_OFS:    read_mux = src_q;
            DMA_DST_OFS:    read_mux = dst_q;
            DMA_LEN_OFS:    read_mux = 32'(len_q);
            DMA_CTRL_OFS:   read_mux = {30'b0, irq_en_q, 1'b0};
            DMA_STATUS_OFS: read_mux = {30'b0, done_q, busy_i};
            DMA_REMAIN_OFS: read_mux = 32'(remain_i);
            default:        read_mux = '0;
        endcase
    end

    always_comb begin
        src_d        = src_q;
        dst_d        = dst_q;
        len_d        = len_q;
        irq_en_d     = irq_en_q;
        done_d       = done_q;
        resp_valid_d = resp_valid_q;
        rdata_d      = rdata_q;

        // Copy parameters are frozen while a transfer is in flight.
        if (wr && !active_i) begin
            case (ofs)
                DMA_SRC_OFS: src_d = cfg_req.wdata;
                DMA_DST_OFS: dst_d = cfg_req.wdata;
                DMA_LEN_OFS: len_d = cfg_req.wdata[LEN_W-1:0];
                default:     ;
            endcase
        end
        if (wr && (ofs == DMA_CTRL_OFS))
            irq_en_d = cfg_req.wdata[1];
        if (wr && (ofs == DMA_STATUS_OFS) && cfg_req.wdata[1])
            done_d = 1'b0;
        if (start_o)
            done_d = 1'b0;
        // Completion outranks a simultaneous software clear.
        if (done_set_i)
            done_d = 1'b1;

        if (resp_valid_q && cfg_resp_ready)
            resp_valid_d = 1'b0;
        if (accept) begin
            resp_valid_d = 1'b1;
            rdata_d      = cfg_req.we ? 32'h0 : read_mux;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            src_q        <= '0;
            dst_q        <= '0;
            len_q        <= '0;
            irq_en_q     <= 1'b0;
            done_q       <= 1'b0;
            resp_valid_q <= 1'b0;
            rdata_q      <= '0;
        end else begin
            src_q        <= src_d;
            dst_q        <= dst_d;
            len_q        <= len_d;
            irq_en_q     <= irq_en_d;
            done_q       <= done_d;
            resp_valid_q <= resp_valid_d;
            rdata_q      <= rdata_d;
        end
    end

    assign cfg_resp_valid = resp_valid_q;
    assign cfg_resp.rdata = rdata_q;
    assign src_o          = src_q;
    assign dst_o          = dst_q;
    assign len_o          = len_q;
    assign done_o         = done_q;
    assign irq_en_o       = irq_en_q;

endmodule

// File: rtl/mem_dma.sv
// Word-granular memory-to-memory copy engine: one read then one write per
// word on the initiator port, level irq on completion.
module mem_dma
    import mem_dma_pkg::*;
#(
    parameter int LEN_W = DMA_LEN_W,
    parameter int OFS_W = DMA_OFS_W
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      cfg_req_valid,
    output logic      cfg_req_ready,
    input  mem_req_t  cfg_req,
    output logic      cfg_resp_valid,
    input  logic      cfg_resp_ready,
    output mem_resp_t cfg_resp,
    output logic      dma_req_valid,
    input  logic      dma_req_ready,
    output mem_req_t  dma_req,
    input  logic      dma_resp_valid,
    output logic      dma_resp_ready,
    input  mem_resp_t dma_resp,
    output logic      dma_irq
);

    dma_state_e       state_q, state_d;
    logic             busy_q, busy_d;
    logic [31:0]      cur_src_q, cur_src_d;
    logic [31:0]      cur_dst_q, cur_dst_d;
    logic [LEN_W-1:0] remain_q, remain_d;
    logic [31:0]      data_q, data_d;

    logic             start;
    logic             done_set;
    logic             done;
    logic             irq_en;
    logic [31:0]      src;
    logic [31:0]      dst;
    logic [LEN_W-1:0] len;

    mem_dma_regs #(
        .LEN_W (LEN_W),
        .OFS_W (OFS_W)
    ) u_regs (
        .clk            (clk),
        .rst            (rst),
        .cfg_req_valid  (cfg_req_valid),
        .cfg_req_ready  (cfg_req_ready),
        .cfg_req        (cfg_req),
        .cfg_resp_valid (cfg_resp_valid),
        .cfg_resp_ready (cfg_resp_ready),
        .cfg_resp       (cfg_resp),
        .active_i       (state_q != IDLE),
        .busy_i         (busy_q),
        .done_set_i     (done_set),
        .remain_i       (remain_q),
        .start_o        (start),
        .src_o          (src),
        .dst_o          (dst),
        .len_o          (len),
        .done_o         (done),
        .irq_en_o       (irq_en)
    );

    always_comb begin
        state_d        = state_q;
        busy_d         = busy_q;
        cur_src_d      = cur_src_q;
        cur_dst_d      = cur_dst_q;
        remain_d       = remain_q;
        data_d         = data_q;
        done_set       = 1'b0;
        dma_req_valid  = 1'b0;
        dma_resp_ready = 1'b0;
        dma_req        = '0;
        dma_req.wstrb  = 4'hF;

        case (state_q)
            IDLE: begin
                if (start) begin
                    cur_src_d = src;
                    cur_dst_d = dst;
                    remain_d  = len;
                    // A zero-length copy still reports completion, but never looks busy.
                    if (len != '0) begin
                        busy_d  = 1'b1;
                        state_d = RD_REQ;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            RD_REQ: begin
                dma_req_valid = 1'b1;
                dma_req.addr  = word_align(cur_src_q);
                if (dma_req_ready)
                    state_d = RD_RESP;
            end
            RD_RESP: begin
                dma_resp_ready = 1'b1;
                if (dma_resp_valid) begin
                    data_d  = dma_resp.rdata;
                    state_d = WR_REQ;
                end
            end
            WR_REQ: begin
                dma_req_valid = 1'b1;
                dma_req.addr  = word_align(cur_dst_q);
                dma_req.wdata = data_q;
                dma_req.we    = 1'b1;
                if (dma_req_ready)
                    state_d = WR_RESP;
            end
            WR_RESP: begin
                dma_resp_ready = 1'b1;
                if (dma_resp_valid) begin
                    cur_src_d = cur_src_q + 32'd4;
                    cur_dst_d = cur_dst_q + 32'd4;
                    remain_d  = remain_q - LEN_W'(1);
                    state_d   = (remain_q > LEN_W'(1)) ? RD_REQ : DONE;
                end
            end
            DONE: begin
                done_set = 1'b1;
                busy_d   = 1'b0;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            busy_q    <= 1'b0;
            cur_src_q <= '0;
            cur_dst_q <= '0;
            remain_q  <= '0;
            data_q    <= '0;
        end else begin
            state_q   <= state_d;
            busy_q    <= busy_d;
            cur_src_q <= cur_src_d;
            cur_dst_q <= cur_dst_d;
            remain_q  <= remain_d;
            data_q    <= data_d;
        end
    end

    assign dma_irq = done & irq_en;

endmodule

// File: tb/tb_mem_dma.sv
// Self-checking bench for mem_dma: scoreboard of expected copy beats derived
// from SRC/DST/LEN, randomised responder stalls, config-port register checks.
`timescale 1ns/1ps
module tb_mem_dma;
    import mem_dma_pkg::*;

    logic      clk = 1'b0;
    logic      rst = 1'b1;
    logic      cfg_req_valid = 1'b0;
    logic      cfg_req_ready;
    mem_req_t  cfg_req;
    logic      cfg_resp_valid;
    logic      cfg_resp_ready = 1'b0;
    mem_resp_t cfg_resp;
    logic      dma_req_valid;
    logic      dma_req_ready = 1'b0;
    mem_req_t  dma_req;
    logic      dma_resp_valid = 1'b0;
    logic      dma_resp_ready;
    mem_resp_t dma_resp;
    logic      dma_irq;

    mem_dma dut (
        .clk            (clk),
        .rst            (rst),
        .cfg_req_valid  (cfg_req_valid),
        .cfg_req_ready  (cfg_req_ready),
        .cfg_req        (cfg_req),
        .cfg_resp_valid (cfg_resp_valid),
        .cfg_resp_ready (cfg_resp_ready),
        .cfg_resp       (cfg_resp),
        .dma_req_valid  (dma_req_valid),
        .dma_req_ready  (dma_req_ready),
        .dma_req        (dma_req),
        .dma_resp_valid (dma_resp_valid),
        .dma_resp_ready (dma_resp_ready),
        .dma_resp       (dma_resp),
        .dma_irq        (dma_irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          we;
        logic [31:0] addr;
        logic [31:0] data;
    } beat_t;

    beat_t       exp_q[$];
    logic [31:0] rd_log[$];
    int          n_cmp = 0;
    int          n_fail = 0;
    int          stall_max = 0;
    int          cyc = 0;
    int          req_valid_cycles = 0;
    int          first_rd_cyc = 0;
    int          last_wr_cyc = 0;
    bit          first_seen = 1'b0;
    logic [31:0] last_wr_addr = '0;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got running expected finished");
        $fatal(1, "watchdog");
    end

    // Source memory contents: a pure function of the word address.
    function automatic logic [31:0] rd_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // A copy is, word by word, a read of SRC+4i followed by a write of that word to DST+4i.
    task automatic plan_copy(input logic [31:0] s, input logic [31:0] d, input int len);
        logic [31:0] ra, wa;
        for (int i = 0; i < len; i++) begin
            ra = {s[31:2], 2'b00} + 32'(4 * i);
            wa = {d[31:2], 2'b00} + 32'(4 * i);
            exp_q.push_back('{we: 1'b0, addr: ra, data: 32'h0});
            exp_q.push_back('{we: 1'b1, addr: wa, data: rd_word(ra)});
        end
    endtask

    // Initiator-port responder and per-cycle compare process.
    initial begin : responder
        mem_req_t    held;
        beat_t       e;
        bit          waiting = 1'b0;
        bit          pending = 1'b0;
        bit          resp_hs = 1'b0;
        int          stall = 0;
        int          rdelay = 0;
        logic [31:0] rdata_next = '0;
        dma_resp = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                dma_req_ready  = 1'b0;
                dma_resp_valid = 1'b0;
                waiting = 1'b0;
                pending = 1'b0;
                resp_hs = 1'b0;
                stall   = 0;
                continue;
            end
            if (dma_req_valid)
                req_valid_cycles++;

            if (resp_hs) begin
                dma_resp_valid = 1'b0;
                pending = 1'b0;
                resp_hs = 1'b0;
            end
            if (!pending)
                chk("resp_ready_idle", dma_resp_ready, 1'b0);
            if (pending && !dma_resp_valid) begin
                if (rdelay == 0) begin
                    dma_resp_valid = 1'b1;
                    dma_resp.rdata = rdata_next;
                end else begin
                    rdelay--;
                end
            end
            resp_hs = dma_resp_valid && dma_resp_ready;

            if (waiting) begin
                chk("req_valid_held", dma_req_valid, 1'b1);
                if (dma_req_valid)
                    chk("req_stable", dma_req, held);
            end
            waiting = 1'b0;
            dma_req_ready = 1'b0;
            if (dma_req_valid) begin
                if (stall > 0) begin
                    stall--;
                    waiting = 1'b1;
                    held = dma_req;
                end else begin
                    dma_req_ready = 1'b1;
                    if (exp_q.size() == 0) begin
                        chk("req_unexpected_valid", dma_req_valid, 1'b0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("req_we", dma_req.we, e.we);
                        chk("req_addr", dma_req.addr, e.addr);
                        chk("req_wstrb", dma_req.wstrb, 4'hF);
                        if (e.we)
                            chk("req_wdata", dma_req.wdata, e.data);
                    end
                    $display("dma %s addr=0x%08h wdata=0x%08h", dma_req.we ? "wr" : "rd",
                             dma_req.addr, dma_req.wdata);
                    if (!dma_req.we) begin
                        rd_log.push_back(dma_req.addr);
                        rdata_next = rd_word(dma_req.addr);
                        if (!first_seen) begin
                            first_seen = 1'b1;
                            first_rd_cyc = cyc;
                        end
                    end else begin
                        rdata_next = $urandom;
                        last_wr_cyc = cyc;
                        last_wr_addr = dma_req.addr;
                    end
                    pending = 1'b1;
                    rdelay = $urandom_range(0, stall_max);
                    stall  = $urandom_range(0, stall_max);
                end
            end
        end
    end

    task automatic cfg_xfer(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                            output logic [31:0] rdata);
        int guard;
        @(negedge clk);
        cfg_req.addr  = addr;
        cfg_req.wdata = wdata;
        cfg_req.wstrb = 4'hF;
        cfg_req.we    = we;
        cfg_req_valid = 1'b1;
        guard = 0;
        while (!cfg_req_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 50)
            chk("cfg_req_ready_timeout", cfg_req_ready, 1'b1);
        @(negedge clk);
        cfg_req_valid = 1'b0;
        chk("cfg_resp_latency", cfg_resp_valid, 1'b1);
        repeat ($urandom_range(0, 2)) begin
            @(negedge clk);
            chk("cfg_resp_held", cfg_resp_valid, 1'b1);
        end
        rdata = cfg_resp.rdata;
        cfg_resp_ready = 1'b1;
        @(negedge clk);
        cfg_resp_ready = 1'b0;
        chk("cfg_resp_drop", cfg_resp_valid, 1'b0);
        if (we)
            chk("cfg_wr_rdata", rdata, 32'h0);
        $display("cfg %s ofs=0x%02h wdata=0x%08h rdata=0x%08h", we ? "wr" : "rd", addr[7:0], wdata, rdata);
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] data);
        logic [31:0] dummy;
        cfg_xfer(1'b1, addr, data, dummy);
    endtask

    task automatic rchk(input string name, input logic [31:0] addr, input logic [31:0] exp);
        logic [31:0] v;
        cfg_xfer(1'b0, addr, 32'h0, v);
        chk(name, v, exp);
    endtask

    task automatic wait_irq(input string name);
        int guard;
        guard = 0;
        while (!dma_irq && guard < 3000) begin
            @(negedge clk);
            guard++;
        end
        chk(name, dma_irq, 1'b1);
    endtask

    initial begin : main
        logic [31:0] s, d, v;
        int          l, vc;
        cfg_req = '0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_cfg_req_ready", cfg_req_ready, 1'b0);
        chk("rst_cfg_resp_valid", cfg_resp_valid, 1'b0);
        chk("rst_dma_req_valid", dma_req_valid, 1'b0);
        chk("rst_dma_resp_ready", dma_resp_ready, 1'b0);
        chk("rst_irq", dma_irq, 1'b0);
        rst = 1'b0;
        rchk("rst_src", DMA_SRC_OFS, 32'h0);
        rchk("rst_len", DMA_LEN_OFS, 32'h0);
        rchk("rst_status", DMA_STATUS_OFS, 32'h0);

        // Basic 4-word copy, zero-latency responder
        stall_max = 0;
        wr(DMA_SRC_OFS, 32'h8000_0000);
        wr(DMA_DST_OFS, 32'h8000_0100);
        wr(DMA_LEN_OFS, 32'd4);
        rchk("basic_src_rb", DMA_SRC_OFS, 32'h8000_0000);
        rchk("basic_dst_rb", DMA_DST_OFS, 32'h8000_0100);
        rchk("unmapped_rd", 32'h18, 32'h0);
        plan_copy(32'h8000_0000, 32'h8000_0100, 4);
        rd_log.delete();
        first_seen = 1'b0;
        wr(DMA_CTRL_OFS, 32'h3);
        wait_irq("basic_irq");
        chk("basic_beats_left", exp_q.size(), 0);
        chk("basic_cycles", last_wr_cyc - first_rd_cyc, 14);
        chk("basic_rd0", rd_log[0], 32'h8000_0000);
        chk("basic_rd3", rd_log[3], 32'h8000_000C);
        chk("basic_last_wr", last_wr_addr, 32'h8000_010C);
        rchk("basic_status", DMA_STATUS_OFS, 32'h2);
        rchk("basic_remain", DMA_REMAIN_OFS, 32'h0);
        rchk("basic_ctrl", DMA_CTRL_OFS, 32'h2);
        wr(DMA_STATUS_OFS, 32'h2);
        chk("w1c_irq", dma_irq, 1'b0);
        rchk("w1c_status", DMA_STATUS_OFS, 32'h0);

        // Zero-length copy: done without traffic, irq follows irq_en
        wr(DMA_LEN_OFS, 32'd0);
        vc = req_valid_cycles;
        wr(DMA_CTRL_OFS, 32'h1);
        rchk("len0_status", DMA_STATUS_OFS, 32'h2);
        chk("len0_no_req", req_valid_cycles - vc, 0);
        chk("len0_irq_off", dma_irq, 1'b0);
        wr(DMA_CTRL_OFS, 32'h2);
        chk("len0_irq_on", dma_irq, 1'b1);
        wr(DMA_STATUS_OFS, 32'h2);
        chk("len0_irq_clr", dma_irq, 1'b0);

        // Address wrap, misaligned destination
        wr(DMA_SRC_OFS, 32'hFFFF_FFFC);
        wr(DMA_DST_OFS, 32'h4000_0001);
        wr(DMA_LEN_OFS, 32'd2);
        plan_copy(32'hFFFF_FFFC, 32'h4000_0001, 2);
        rd_log.delete();
        wr(DMA_CTRL_OFS, 32'h3);
        wait_irq("wrap_irq");
        chk("wrap_beats_left", exp_q.size(), 0);
        chk("wrap_nreads", rd_log.size(), 2);
        if (rd_log.size() == 2) begin
            chk("wrap_rd0", rd_log[0], 32'hFFFF_FFFC);
            chk("wrap_rd1", rd_log[1], 32'h0000_0000);
        end

        // Long copy with stalls; config writes while busy are ignored
        stall_max = 5;
        s = 32'h1000_0040;
        d = 32'h2000_0800;
        wr(DMA_SRC_OFS, s);
        wr(DMA_DST_OFS, d);
        wr(DMA_LEN_OFS, 32'd20);
        plan_copy(s, d, 20);
        wr(DMA_CTRL_OFS, 32'h3);
        wr(DMA_SRC_OFS, 32'h1234);
        wr(DMA_LEN_OFS, 32'd5);
        wr(DMA_CTRL_OFS, 32'h3);
        rchk("busy_src_kept", DMA_SRC_OFS, s);
        rchk("busy_len_kept", DMA_LEN_OFS, 32'd20);
        cfg_xfer(1'b0, DMA_STATUS_OFS, 32'h0, v);
        chk("busy_bit", v[0], 1'b1);
        wait_irq("busy_irq");
        chk("busy_beats_left", exp_q.size(), 0);
        rchk("busy_remain", DMA_REMAIN_OFS, 32'h0);

        // Randomised copies with stalls and misaligned pointers
        for (int t = 0; t < 4; t++) begin
            s = $urandom;
            d = $urandom;
            l = $urandom_range(1, 8);
            wr(DMA_SRC_OFS, s);
            wr(DMA_DST_OFS, d);
            wr(DMA_LEN_OFS, 32'(l));
            plan_copy(s, d, l);
            wr(DMA_CTRL_OFS, 32'h3);
            wait_irq("rand_irq");
            chk("rand_beats_left", exp_q.size(), 0);
            rchk("rand_status", DMA_STATUS_OFS, 32'h2);
        end

        // Reset while a write request is pending
        stall_max = 0;
        wr(DMA_SRC_OFS, 32'h3000_0000);
        wr(DMA_DST_OFS, 32'h3000_1000);
        wr(DMA_LEN_OFS, 32'd3);
        plan_copy(32'h3000_0000, 32'h3000_1000, 3);
        wr(DMA_CTRL_OFS, 32'h3);
        l = 0;
        while (!(dma_req_valid && dma_req.we) && l < 200) begin
            @(negedge clk);
            l++;
        end
        chk("rstmid_reach_wr", dma_req_valid && dma_req.we, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        chk("rstmid_req_valid", dma_req_valid, 1'b0);
        chk("rstmid_resp_ready", dma_resp_ready, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        rchk("rstmid_src", DMA_SRC_OFS, 32'h0);
        rchk("rstmid_dst", DMA_DST_OFS, 32'h0);
        rchk("rstmid_len", DMA_LEN_OFS, 32'h0);
        rchk("rstmid_ctrl", DMA_CTRL_OFS, 32'h0);
        rchk("rstmid_status", DMA_STATUS_OFS, 32'h0);
        rchk("rstmid_remain", DMA_REMAIN_OFS, 32'h0);
        chk("rstmid_irq", dma_irq, 1'b0);
        repeat (5) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
